// File: rtl/ara_cmd_issue_pkg.sv
// Shared types and default sizing for the Ara command issue stage.
// Entry structs are packed so they pass straight through the generic FIFO.
package ara_cmd_issue_pkg;

    localparam int INSN_W              = 32;
    localparam int XLEN                = 64;
    localparam int FRM_W               = 2;
    localparam int TRANS_ID_MAX_W      = 8;
    localparam int TRANS_ID_W_DEF      = 3;
    localparam int CMD_DEPTH_DEF       = 4;
    localparam int RSP_DEPTH_DEF       = 2;
    localparam int MAX_OUTSTANDING_DEF = 4;

    typedef struct packed {
        logic [INSN_W-1:0] insn;
        logic [XLEN-1:0]   rs1;
        logic [XLEN-1:0]   rs2;
        logic [FRM_W-1:0]  frm;
    } cmd_entry_t;

    // trans_id is sized for the widest supported ID; narrower IDs are zero-extended
    typedef struct packed {
        logic [XLEN-1:0]           result;
        logic [TRANS_ID_MAX_W-1:0] trans_id;
    } rsp_entry_t;

endpackage

// File: rtl/ara_issue_fifo.sv
// Generic synchronous FIFO; the head is read directly from the storage registers,
// so a pushed entry is visible one cycle later (no fall-through).
module ara_issue_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_en;
    logic             pop_en;

    // Extra pointer MSB distinguishes full from empty when the indices match
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign push_en = push_i && !full_o;
    assign pop_en  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/ara_cmd_issue.sv
// Issue stage in front of the Ara wrapper: command FIFO, trans-ID stamping,
// outstanding bound, in-order response check, response FIFO. Optional perf
// counters are enabled with `define ARA_CMD_ISSUE_PERF_EN.
module ara_cmd_issue
    import ara_cmd_issue_pkg::*;
#(
    parameter int TRANS_ID_WIDTH  = TRANS_ID_W_DEF,
    parameter int CMD_DEPTH       = CMD_DEPTH_DEF,
    parameter int RSP_DEPTH       = RSP_DEPTH_DEF,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 cmd_valid_i,
    output logic                                 cmd_ready_o,
    input  logic [31:0]                          cmd_insn_i,
    input  logic [63:0]                          cmd_rs1_i,
    input  logic [63:0]                          cmd_rs2_i,
    input  logic [1:0]                           cmd_frm_i,
    input  logic                                 store_pending_i,
    output logic                                 req_req_valid_o,
    output logic                                 req_resp_ready_o,
    output logic [31:0]                          req_insn_o,
    output logic [63:0]                          req_rs1_o,
    output logic [63:0]                          req_rs2_o,
    output logic [1:0]                           req_frm_o,
    output logic [TRANS_ID_WIDTH-1:0]            req_trans_id_o,
    output logic                                 req_store_pending_o,
    output logic                                 req_acc_cons_en_o,
    output logic                                 req_inval_ready_o,
    input  logic                                 resp_req_ready_i,
    input  logic                                 resp_resp_valid_i,
    input  logic [63:0]                          resp_result_i,
    input  logic [TRANS_ID_WIDTH-1:0]            resp_trans_id_i,
    output logic                                 rsp_valid_o,
    input  logic                                 rsp_ready_i,
    output logic [63:0]                          rsp_result_o,
    output logic [TRANS_ID_WIDTH-1:0]            rsp_trans_id_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 idle_o,
    output logic                                 id_err_o
`ifdef ARA_CMD_ISSUE_PERF_EN
    ,
    output logic [31:0]                          perf_issued_o,
    output logic [31:0]                          perf_stall_full_o,
    output logic [31:0]                          perf_stall_ara_o
`endif
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING+1);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

    cmd_entry_t cmd_wdata;
    cmd_entry_t cmd_head;
    rsp_entry_t rsp_wdata;
    rsp_entry_t rsp_head;

    logic cmd_full, cmd_empty;
    logic rsp_full, rsp_empty;
    logic issue, capture;
    logic rsp_id_unused;

    logic [TRANS_ID_WIDTH-1:0] next_id_q, next_id_d;
    logic [TRANS_ID_WIDTH-1:0] expected_id_q, expected_id_d;
    logic [OUT_W-1:0]          outstanding_q, outstanding_d;
    logic                      id_err_q, id_err_d;

    assign cmd_wdata = '{insn: cmd_insn_i, rs1: cmd_rs1_i, rs2: cmd_rs2_i, frm: cmd_frm_i};
    assign rsp_wdata = '{result: resp_result_i, trans_id: TRANS_ID_MAX_W'(resp_trans_id_i)};

    ara_issue_fifo #(
        .WIDTH ($bits(cmd_entry_t)),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (cmd_valid_i),
        .data_i  (cmd_wdata),
        .pop_i   (issue),
        .data_o  (cmd_head),
        .full_o  (cmd_full),
        .empty_o (cmd_empty)
    );

    ara_issue_fifo #(
        .WIDTH ($bits(rsp_entry_t)),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (capture),
        .data_i  (rsp_wdata),
        .pop_i   (rsp_ready_i),
        .data_o  (rsp_head),
        .full_o  (rsp_full),
        .empty_o (rsp_empty)
    );

    // Valid cannot drop once raised: the head only moves on issue and the count only falls otherwise
    assign req_req_valid_o  = !cmd_empty && (outstanding_q < OUT_MAX);
    assign issue            = req_req_valid_o && resp_req_ready_i;
    assign capture          = resp_resp_valid_i && req_resp_ready_o;

    assign cmd_ready_o         = !cmd_full;
    assign req_resp_ready_o    = !rsp_full;
    assign req_insn_o          = cmd_head.insn;
    assign req_rs1_o           = cmd_head.rs1;
    assign req_rs2_o           = cmd_head.rs2;
    assign req_frm_o           = cmd_head.frm;
    assign req_trans_id_o      = next_id_q;
    assign req_store_pending_o = store_pending_i;
    assign req_acc_cons_en_o   = 1'b0;
    assign req_inval_ready_o   = 1'b1;

    assign rsp_valid_o    = !rsp_empty;
    assign rsp_result_o   = rsp_head.result;
    assign rsp_trans_id_o = rsp_head.trans_id[TRANS_ID_WIDTH-1:0];
    assign rsp_id_unused  = ^rsp_head.trans_id;

    assign outstanding_o = outstanding_q;
    assign idle_o        = cmd_empty && rsp_empty && (outstanding_q == '0);
    assign id_err_o      = id_err_q;

    always_comb begin
        next_id_d     = next_id_q;
        expected_id_d = expected_id_q;
        outstanding_d = outstanding_q;
        id_err_d      = id_err_q;
        if (issue) begin
            next_id_d = next_id_q + 1'b1;
        end
        if (capture) begin
            expected_id_d = expected_id_q + 1'b1;
            if ((resp_trans_id_i != expected_id_q) || (outstanding_q == '0)) begin
                id_err_d = 1'b1;
            end
        end
        // A capture with nothing in flight does not decrement, so the count saturates at zero
        case ({issue, capture && (outstanding_q != '0)})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            next_id_q     <= '0;
            expected_id_q <= '0;
            outstanding_q <= '0;
            id_err_q      <= 1'b0;
        end else begin
            next_id_q     <= next_id_d;
            expected_id_q <= expected_id_d;
            outstanding_q <= outstanding_d;
            id_err_q      <= id_err_d;
        end
    end

`ifdef ARA_CMD_ISSUE_PERF_EN
    logic [31:0] perf_issued_q, perf_issued_d;
    logic [31:0] perf_stall_full_q, perf_stall_full_d;
    logic [31:0] perf_stall_ara_q, perf_stall_ara_d;

    always_comb begin
        perf_issued_d     = perf_issued_q;
        perf_stall_full_d = perf_stall_full_q;
        perf_stall_ara_d  = perf_stall_ara_q;
        if (issue) begin
            perf_issued_d = perf_issued_q + 32'd1;
        end
        if (!cmd_empty && (outstanding_q == OUT_MAX)) begin
            perf_stall_full_d = perf_stall_full_q + 32'd1;
        end
        if (req_req_valid_o && !resp_req_ready_i) begin
            perf_stall_ara_d = perf_stall_ara_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_issued_q     <= '0;
            perf_stall_full_q <= '0;
            perf_stall_ara_q  <= '0;
        end else begin
            perf_issued_q     <= perf_issued_d;
            perf_stall_full_q <= perf_stall_full_d;
            perf_stall_ara_q  <= perf_stall_ara_d;
        end
    end

    assign perf_issued_o     = perf_issued_q;
    assign perf_stall_full_o = perf_stall_full_q;
    assign perf_stall_ara_o  = perf_stall_ara_q;
`endif

endmodule

// File: tb/tb_ara_cmd_issue.sv
// Scoreboard bench for ara_cmd_issue: drivers push expected requests/responses,
// a negedge monitor pops and compares them on every DUT handshake.
module tb_ara_cmd_issue;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [31:0] cmd_insn_i = '0;
    logic [63:0] cmd_rs1_i = '0;
    logic [63:0] cmd_rs2_i = '0;
    logic [1:0]  cmd_frm_i = '0;
    logic        store_pending_i = 1'b0;
    logic        req_req_valid_o;
    logic        req_resp_ready_o;
    logic [31:0] req_insn_o;
    logic [63:0] req_rs1_o;
    logic [63:0] req_rs2_o;
    logic [1:0]  req_frm_o;
    logic [2:0]  req_trans_id_o;
    logic        req_store_pending_o;
    logic        req_acc_cons_en_o;
    logic        req_inval_ready_o;
    logic        resp_req_ready_i = 1'b0;
    logic        resp_resp_valid_i = 1'b0;
    logic [63:0] resp_result_i = '0;
    logic [2:0]  resp_trans_id_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [63:0] rsp_result_o;
    logic [2:0]  rsp_trans_id_o;
    logic [2:0]  outstanding_o;
    logic        idle_o;
    logic        id_err_o;
`ifdef ARA_CMD_ISSUE_PERF_EN
    logic [31:0] perf_issued_o;
    logic [31:0] perf_stall_full_o;
    logic [31:0] perf_stall_ara_o;
`endif

    ara_cmd_issue dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .cmd_valid_i         (cmd_valid_i),
        .cmd_ready_o         (cmd_ready_o),
        .cmd_insn_i          (cmd_insn_i),
        .cmd_rs1_i           (cmd_rs1_i),
        .cmd_rs2_i           (cmd_rs2_i),
        .cmd_frm_i           (cmd_frm_i),
        .store_pending_i     (store_pending_i),
        .req_req_valid_o     (req_req_valid_o),
        .req_resp_ready_o    (req_resp_ready_o),
        .req_insn_o          (req_insn_o),
        .req_rs1_o           (req_rs1_o),
        .req_rs2_o           (req_rs2_o),
        .req_frm_o           (req_frm_o),
        .req_trans_id_o      (req_trans_id_o),
        .req_store_pending_o (req_store_pending_o),
        .req_acc_cons_en_o   (req_acc_cons_en_o),
        .req_inval_ready_o   (req_inval_ready_o),
        .resp_req_ready_i    (resp_req_ready_i),
        .resp_resp_valid_i   (resp_resp_valid_i),
        .resp_result_i       (resp_result_i),
        .resp_trans_id_i     (resp_trans_id_i),
        .rsp_valid_o         (rsp_valid_o),
        .rsp_ready_i         (rsp_ready_i),
        .rsp_result_o        (rsp_result_o),
        .rsp_trans_id_o      (rsp_trans_id_o),
        .outstanding_o       (outstanding_o),
        .idle_o              (idle_o),
        .id_err_o            (id_err_o)
`ifdef ARA_CMD_ISSUE_PERF_EN
        ,
        .perf_issued_o       (perf_issued_o),
        .perf_stall_full_o   (perf_stall_full_o),
        .perf_stall_ara_o    (perf_stall_ara_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] insn;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [1:0]  frm;
        logic [2:0]  id;
    } req_t;

    typedef struct {
        logic [63:0] result;
        logic [2:0]  id;
    } rsp_t;

    req_t exp_req[$];
    rsp_t exp_rsp[$];
    req_t mon_req;
    rsp_t mon_rsp;
    logic [2:0] exp_next_id = '0;
    int n_checks = 0;
    int n_fail   = 0;
    int n_issued = 0;

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endfunction

    // Monitor: handshakes complete at the next rising edge, so sample on the falling edge
    always @(negedge clk_i) begin
        if (!rst_i && req_req_valid_o && resp_req_ready_i) begin
            n_issued++;
            if (exp_req.size() == 0) begin
                check("req_unexpected", 64'd1, 64'd0);
            end else begin
                mon_req = exp_req.pop_front();
                check("req_insn", 64'(req_insn_o), 64'(mon_req.insn));
                check("req_rs1", req_rs1_o, mon_req.rs1);
                check("req_rs2", req_rs2_o, mon_req.rs2);
                check("req_frm", 64'(req_frm_o), 64'(mon_req.frm));
                check("req_trans_id", 64'(req_trans_id_o), 64'(mon_req.id));
            end
        end
        if (!rst_i && rsp_valid_o && rsp_ready_i) begin
            if (exp_rsp.size() == 0) begin
                check("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                mon_rsp = exp_rsp.pop_front();
                check("rsp_result", rsp_result_o, mon_rsp.result);
                check("rsp_trans_id", 64'(rsp_trans_id_o), 64'(mon_rsp.id));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        cmd_valid_i = 1'b0;
        resp_resp_valid_i = 1'b0;
        exp_req.delete();
        exp_rsp.delete();
        exp_next_id = '0;
        n_issued = 0;
        tick(2);
        rst_i = 1'b0;
    endtask

    task automatic push_cmd(input logic [31:0] insn, input logic [63:0] rs1,
                            input logic [63:0] rs2, input logic [1:0] frm);
        req_t e;
        logic ok;
        ok = 1'b0;
        cmd_valid_i = 1'b1;
        cmd_insn_i = insn;
        cmd_rs1_i = rs1;
        cmd_rs2_i = rs2;
        cmd_frm_i = frm;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk_i);
            ok = cmd_ready_o;
            @(posedge clk_i);
            #1;
        end
        cmd_valid_i = 1'b0;
        if (ok) begin
            e.insn = insn;
            e.rs1 = rs1;
            e.rs2 = rs2;
            e.frm = frm;
            e.id = exp_next_id;
            exp_next_id = exp_next_id + 3'd1;
            exp_req.push_back(e);
        end else begin
            check("cmd_accept_timeout", 64'd0, 64'd1);
        end
    endtask

    task automatic respond(input logic [63:0] result, input logic [2:0] id);
        rsp_t e;
        logic ok;
        ok = 1'b0;
        resp_resp_valid_i = 1'b1;
        resp_result_i = result;
        resp_trans_id_i = id;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk_i);
            ok = req_resp_ready_o;
            @(posedge clk_i);
            #1;
        end
        resp_resp_valid_i = 1'b0;
        if (ok) begin
            e.result = result;
            e.id = id;
            exp_rsp.push_back(e);
        end else begin
            check("resp_accept_timeout", 64'd0, 64'd1);
        end
    endtask

    task automatic wait_issues(input int n);
        logic ok;
        ok = (n_issued >= n);
        for (int k = 0; k < 50 && !ok; k++) begin
            tick(1);
            ok = (n_issued >= n);
        end
        if (!ok) check("issue_timeout", 64'(n_issued), 64'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: reset state, single command latency
        do_reset();
        @(negedge clk_i);
        check("rst_req_valid", 64'(req_req_valid_o), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
        check("rst_resp_ready", 64'(req_resp_ready_o), 64'd1);
        check("rst_idle", 64'(idle_o), 64'd1);
        check("rst_outstanding", 64'(outstanding_o), 64'd0);
        check("rst_id_err", 64'(id_err_o), 64'd0);
        check("acc_cons_en", 64'(req_acc_cons_en_o), 64'd0);
        check("inval_ready", 64'(req_inval_ready_o), 64'd1);
        store_pending_i = 1'b1;
        #1;
        check("store_pending_pass", 64'(req_store_pending_o), 64'd1);
        store_pending_i = 1'b0;
        @(posedge clk_i);
        #1;
        resp_req_ready_i = 1'b1;
        rsp_ready_i = 1'b1;
        push_cmd(32'h0200_7057, 64'd16, 64'd0, 2'd0);
        @(negedge clk_i);
        check("t1_valid_after_accept", 64'(req_req_valid_o), 64'd1);
        check("t1_trans_id", 64'(req_trans_id_o), 64'd0);
        tick(1);
        check("t1_outstanding", 64'(outstanding_o), 64'd1);
        check("t1_valid_drop", 64'(req_req_valid_o), 64'd0);
        respond(64'h1234, 3'd0);
        tick(3);
        check("t1_idle", 64'(idle_o), 64'd1);
        check("t1_rsp_drained", 64'(exp_rsp.size()), 64'd0);

        // 2: outstanding bound with a silent Ara
        do_reset();
        for (int i = 0; i < 6; i++) begin
            push_cmd(32'h1000 + 32'(i), 64'(i * 3), 64'(100 + i), 2'(i));
        end
        tick(5);
        check("t2_issued", 64'(n_issued), 64'd4);
        check("t2_outstanding", 64'(outstanding_o), 64'd4);
        check("t2_valid_blocked", 64'(req_req_valid_o), 64'd0);
        check("t2_queued", 64'(exp_req.size()), 64'd2);
        check("t2_not_idle", 64'(idle_o), 64'd0);
        respond(64'hA0, 3'd0);
        wait_issues(5);
        check("t2_outstanding_refill", 64'(outstanding_o), 64'd4);
        check("t2_issued_after_rsp", 64'(n_issued), 64'd5);

        // 3: nine in-order round trips, ID wraps 7 -> 0
        do_reset();
        for (int i = 0; i < 9; i++) begin
            push_cmd(32'h2000 + 32'(i), 64'(i), 64'(i + 1), 2'd3);
            wait_issues(i + 1);
            respond(64'hC000 + 64'(i), 3'(i));
        end
        tick(4);
        check("t3_id_err", 64'(id_err_o), 64'd0);
        check("t3_idle", 64'(idle_o), 64'd1);
        check("t3_outstanding", 64'(outstanding_o), 64'd0);
        check("t3_rsp_drained", 64'(exp_rsp.size()), 64'd0);

        // 4: out-of-order ID is forwarded and latches the error flag
        do_reset();
        push_cmd(32'h3000, 64'd1, 64'd2, 2'd1);
        wait_issues(1);
        respond(64'hBAD, 3'd2);
        check("t4_id_err_set", 64'(id_err_o), 64'd1);
        tick(5);
        check("t4_id_err_sticky", 64'(id_err_o), 64'd1);
        check("t4_idle", 64'(idle_o), 64'd1);
        check("t4_rsp_delivered", 64'(exp_rsp.size()), 64'd0);
        do_reset();
        check("t4_id_err_cleared", 64'(id_err_o), 64'd0);

        // 5: response FIFO backpressure
        rsp_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_cmd(32'h4000 + 32'(i), 64'd0, 64'd0, 2'd0);
        end
        wait_issues(3);
        respond(64'h5555_0000, 3'd0);
        respond(64'h5555_0001, 3'd1);
        @(negedge clk_i);
        check("t5_resp_ready_low", 64'(req_resp_ready_o), 64'd0);
        check("t5_rsp_valid", 64'(rsp_valid_o), 64'd1);
        resp_resp_valid_i = 1'b1;
        resp_result_i = 64'h5555_0002;
        resp_trans_id_i = 3'd2;
        tick(3);
        check("t5_held_outstanding", 64'(outstanding_o), 64'd1);
        resp_resp_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        respond(64'h5555_0002, 3'd2);
        tick(4);
        check("t5_rsp_drained", 64'(exp_rsp.size()), 64'd0);
        check("t5_idle", 64'(idle_o), 64'd1);
        check("t5_id_err", 64'(id_err_o), 64'd0);

        // 6: simultaneous issue and capture, then asynchronous reset mid-burst
        do_reset();
        rsp_ready_i = 1'b0;
        resp_req_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_cmd(32'h6000 + 32'(i), 64'(i), 64'd0, 2'd2);
        end
        resp_req_ready_i = 1'b1;
        wait_issues(2);
        resp_req_ready_i = 1'b0;
        check("t6_outstanding_2", 64'(outstanding_o), 64'd2);
        resp_req_ready_i = 1'b1;
        resp_resp_valid_i = 1'b1;
        resp_result_i = 64'h6666;
        resp_trans_id_i = 3'd0;
        @(negedge clk_i);
        check("t6_both_handshakes", 64'({req_req_valid_o, req_resp_ready_o}), 64'd3);
        tick(1);
        resp_resp_valid_i = 1'b0;
        resp_req_ready_i = 1'b0;
        exp_rsp.push_back('{result: 64'h6666, id: 3'd0});
        check("t6_outstanding_same", 64'(outstanding_o), 64'd2);
        push_cmd(32'h6100, 64'd7, 64'd8, 2'd0);
        respond(64'h6667, 3'd1);
        check("t6_pre_rst_req_valid", 64'(req_req_valid_o), 64'd1);
        check("t6_pre_rst_rsp_valid", 64'(rsp_valid_o), 64'd1);
        #2;
        rst_i = 1'b1;
        #1;
        check("t6_async_req_valid", 64'(req_req_valid_o), 64'd0);
        check("t6_async_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("t6_async_cmd_ready", 64'(cmd_ready_o), 64'd1);
        check("t6_async_resp_ready", 64'(req_resp_ready_o), 64'd1);
        check("t6_async_idle", 64'(idle_o), 64'd1);
        check("t6_async_outstanding", 64'(outstanding_o), 64'd0);
        check("t6_async_id_err", 64'(id_err_o), 64'd0);
        do_reset();
        tick(2);
        check("t6_post_rst_idle", 64'(idle_o), 64'd1);
        check("t6_no_replay", 64'(req_req_valid_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ara_cmd_issue.md
Name: ara_cmd_issue

Overview:
Issue stage directly upstream of the Ara accelerator wrapper; consumes scalar-core vector commands and drives the wrapper's flattened req_*/resp_* accelerator port.
- Buffers commands in a small FIFO and stamps each with a wrapping transaction ID.
- Bounds outstanding requests and checks that Ara responses return in order.
- Buffers responses back to the core with valid/ready backpressure.

Parameters:
TRANS_ID_WIDTH, 3, width of trans_id; must match the downstream wrapper.
CMD_DEPTH, 4, command FIFO entries; power of 2, >=2.
RSP_DEPTH, 2, response FIFO entries; power of 2, >=2.
MAX_OUTSTANDING, 4, max issued-but-unanswered requests; 1..2**TRANS_ID_WIDTH.

Ports:
clk_i  in  1  clock; all logic rising-edge.
rst_i  in  1  asynchronous, active-high reset.
cmd_valid_i  in  1  core command valid.
cmd_ready_o  out  1  command FIFO not full.
cmd_insn_i  in  32  vector instruction.
cmd_rs1_i  in  64  scalar operand 1.
cmd_rs2_i  in  64  scalar operand 2.
cmd_frm_i  in  2  FP rounding mode.
store_pending_i  in  1  core has pending scalar stores; passed through combinationally.
req_req_valid_o  out  1  request valid to Ara.
req_resp_ready_o  out  1  response FIFO not full.
req_insn_o / req_rs1_o / req_rs2_o / req_frm_o  out  32/64/64/2  head-of-FIFO fields.
req_trans_id_o  out  TRANS_ID_WIDTH  ID of the head request.
req_store_pending_o  out  1  equals store_pending_i.
req_acc_cons_en_o  out  1  constant 0.
req_inval_ready_o  out  1  constant 1.
resp_req_ready_i  in  1  Ara accepts a request.
resp_resp_valid_i  in  1  Ara response valid.
resp_result_i  in  64  Ara result.
resp_trans_id_i  in  TRANS_ID_WIDTH  Ara response ID.
rsp_valid_o  out  1  response to core valid.
rsp_ready_i  in  1  core accepts the response.
rsp_result_o  out  64  result.
rsp_trans_id_o  out  TRANS_ID_WIDTH  response ID.
outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  in-flight request count.
idle_o  out  1  both FIFOs empty and outstanding==0.
id_err_o  out  1  sticky in-order ID violation flag.

Behaviour:
- Reset values (asynchronous on rst_i high): FIFOs empty; next_id=0; expected_id=0; outstanding=0; id_err_o=0. Hence req_req_valid_o=0, rsp_valid_o=0, cmd_ready_o=1, req_resp_ready_o=1, idle_o=1.
- Command accept: on cmd_valid_i&&cmd_ready_o, the entry {insn,rs1,rs2,frm} is written. The FIFO is not fall-through, so an entry can be issued 1 cycle after acceptance at the earliest.
- Issue condition: req_req_valid_o = cmd FIFO non-empty && outstanding<MAX_OUTSTANDING.
  - Handshake is req_req_valid_o&&resp_req_ready_i.
  - On handshake: pop the FIFO; the entry carries req_trans_id_o=next_id; next_id increments modulo 2**TRANS_ID_WIDTH.
- Valid stability: once asserted, req_req_valid_o and its payload stay stable until the handshake. A full outstanding count cannot drop valid, because a count only decrements.
- Response capture: on resp_resp_valid_i&&req_resp_ready_o, push {result,trans_id} into the response FIFO and increment expected_id (wrapping).
  - If resp_trans_id_i != expected_id, set id_err_o; it clears only on reset. The response is still forwarded.
- Outstanding count: +1 on issue and -1 on response capture; simultaneous issue and capture leaves it unchanged. A capture with outstanding==0 also sets id_err_o and leaves the count saturated at 0.
- Response FIFO to core: output is registered; rsp_valid_o = non-empty; pop on rsp_valid_o&&rsp_ready_i.
- Full FIFOs:
  - cmd FIFO full: cmd_ready_o=0.
  - rsp FIFO full: req_resp_ready_o=0, which backpressures Ara.
- Simultaneous push and pop on a full FIFO is not permitted, since ready is low. On an empty FIFO, push and pop in the same cycle is impossible: pop requires non-empty.
- Reset mid-operation: all in-flight state is discarded; no request or response is replayed.

Optional Feature:
ARA_CMD_ISSUE_PERF_EN
- Defined: adds 32-bit wrapping counters with output ports perf_issued_o, perf_stall_full_o and perf_stall_ara_o, all reset to 0.
  - perf_issued_o increments on each issue handshake.
  - perf_stall_full_o increments on cycles where the FIFO is non-empty and outstanding==MAX_OUTSTANDING.
  - perf_stall_ara_o increments on cycles where req_req_valid_o && !resp_req_ready_i.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package ara_cmd_issue_pkg: cmd_entry_t {insn, rs1, rs2, frm} and rsp_entry_t {result, trans_id}, both parameterised via localparam widths, plus default depth constants.
- One sub-module ara_issue_fifo (generic synchronous FIFO with registered output, full/empty flags), instantiated twice.

Test Plan:
1. Reset, then push 1 command (insn=0x0200_7057, rs1=16) with resp_req_ready_i=1 -> req_req_valid_o rises 1 cycle after acceptance; req_trans_id_o=0; outstanding_o=1.
2. Push 6 commands, Ara never responds, MAX_OUTSTANDING=4 -> exactly 4 issues (IDs 0..3); req_req_valid_o stays 0 with 2 commands queued; next accept after 1 response.
3. Issue 9 commands with immediate responses in order -> IDs 0..7,0 (wrap); id_err_o stays 0; idle_o=1 at end.
4. Respond with trans_id=2 while expected_id=0 -> response still delivered; id_err_o=1 and remains set until rst_i.
5. Hold rsp_ready_i=0, return 3 responses with RSP_DEPTH=2 -> req_resp_ready_o=0 after 2; release rsp_ready_i -> results delivered in order.
6. Same-cycle issue and response with outstanding=2 -> outstanding_o stays 2; assert rst_i mid-burst -> all outputs return to reset values asynchronously.
